// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm controller: minute-boundary trigger, snooze with bounded repeats,
// ring timeout and a button-stepped preview display feeding the 7-segment digits.
module multi_alarm_ctrl #(
   parameter int unsigned NUM_ALARMS     = 4,
   parameter int unsigned PREVIEW_CYCLES = 1000000,
   parameter int unsigned SNOOZE_MIN     = 5,
   parameter int unsigned RING_SEC       = 59,
   parameter int unsigned MAX_SNOOZE     = 3,
   localparam int unsigned RIDW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sw0,
   input  logic [5:0]                c_hour,
   input  logic [5:0]                c_min,
   input  logic [5:0]                c_sec,
   input  logic [6*NUM_ALARMS-1:0]   a_hr_flat,
   input  logic [6*NUM_ALARMS-1:0]   a_min_flat,
   input  logic [NUM_ALARMS-1:0]     a_en,
   input  logic                      btn_sel,
   input  logic                      btn_snooze,
   input  logic                      btn_dismiss,
   output logic [3:0]                hr1,
   output logic [3:0]                hr2,
   output logic [3:0]                min1,
   output logic [3:0]                min2,
   output logic                      alarm,
   output logic [RIDW-1:0]           ring_id,
   output logic                      snoozed
);

   localparam int unsigned SW  = $clog2(NUM_ALARMS + 1);
   localparam int unsigned TW  = $clog2(PREVIEW_CYCLES + 1);
   localparam int unsigned SNW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
   localparam logic [SW-1:0]  SEL_MAX   = SW'(NUM_ALARMS);
   localparam logic [TW-1:0]  TMR_LOAD  = TW'(PREVIEW_CYCLES);
   localparam logic [TW-1:0]  TMR_ONE   = TW'(1);
   localparam logic [5:0]     RING_LAST = 6'(RING_SEC - 1);
   localparam logic [SNW-1:0] SNZ_MAX   = SNW'(MAX_SNOOZE);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

   state_t          state, state_n;
   logic [5:0]      ring_cnt, ring_cnt_n;
   logic [SNW-1:0]  snooze_cnt, snooze_cnt_n;
   logic [RIDW-1:0] id_n;
   logic [5:0]      tgt_hr, tgt_hr_n, tgt_min, tgt_min_n;
   logic            sel_q, snz_q, dis_q;
   logic [5:0]      c_sec_q;
   logic [SW-1:0]   disp_sel;
   logic [TW-1:0]   prev_tmr;

   logic            sel_p, snz_p, dis_p, sec_tick, min_bnd;
   logic            hit;
   logic [RIDW-1:0] hit_idx;
   logic [6:0]      min_sum;
   logic [5:0]      snz_hr, snz_min, hr_inc;
   logic [5:0]      sel_hr, sel_min;

   assign sel_p    = btn_sel & ~sel_q;
   assign snz_p    = btn_snooze & ~snz_q;
   assign dis_p    = btn_dismiss & ~dis_q;
   assign sec_tick = (c_sec != c_sec_q);
   assign min_bnd  = sec_tick && (c_sec == 6'd0);

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned k = 0; k < NUM_ALARMS; k++) begin
         if (!hit && a_en[k] && a_hr_flat[6*k +: 6] == c_hour && a_min_flat[6*k +: 6] == c_min) begin
            hit     = 1'b1;
            hit_idx = RIDW'(k);
         end
      end
   end

   always_comb begin
      min_sum = {1'b0, c_min} + 7'(SNOOZE_MIN);
      hr_inc  = c_hour;
      snz_min = min_sum[5:0];
      if (min_sum >= 7'd60) begin
         snz_min = 6'(min_sum - 7'd60);
         hr_inc  = c_hour + 6'd1;
      end
      snz_hr = (hr_inc >= 6'd24) ? 6'd0 : hr_inc;
   end

   always_comb begin
      state_n      = state;
      ring_cnt_n   = ring_cnt;
      snooze_cnt_n = snooze_cnt;
      id_n         = ring_id;
      tgt_hr_n     = tgt_hr;
      tgt_min_n    = tgt_min;
      if (!sw0) begin
         state_n      = IDLE;
         ring_cnt_n   = '0;
         snooze_cnt_n = '0;
      end else begin
         unique case (state)
            IDLE: if (min_bnd && hit) begin
               state_n      = RING;
               id_n         = hit_idx;
               ring_cnt_n   = '0;
               snooze_cnt_n = '0;
            end
            RING: begin
               if (dis_p) begin
                  state_n = IDLE;
               end else if (snz_p) begin
                  if (snooze_cnt >= SNZ_MAX) begin
                     state_n = IDLE;
                  end else begin
                     state_n      = SNOOZE;
                     tgt_hr_n     = snz_hr;
                     tgt_min_n    = snz_min;
                     snooze_cnt_n = snooze_cnt + 1'b1;
                  end
               end else if (sec_tick) begin
                  if (ring_cnt == RING_LAST) state_n = IDLE;
                  else ring_cnt_n = ring_cnt + 6'd1;
               end
            end
            SNOOZE: begin
               if (dis_p) begin
                  state_n = IDLE;
               end else if (min_bnd && c_hour == tgt_hr && c_min == tgt_min) begin
                  state_n    = RING;
                  ring_cnt_n = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      sel_hr  = c_hour;
      sel_min = c_min;
      for (int unsigned k = 0; k < NUM_ALARMS; k++) begin
         if (disp_sel == SW'(k + 1)) begin
            sel_hr  = a_hr_flat[6*k +: 6];
            sel_min = a_min_flat[6*k +: 6];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ring_cnt   <= '0;
         snooze_cnt <= '0;
         ring_id    <= '0;
         tgt_hr     <= '0;
         tgt_min    <= '0;
         alarm      <= 1'b0;
         snoozed    <= 1'b0;
         sel_q      <= 1'b0;
         snz_q      <= 1'b0;
         dis_q      <= 1'b0;
         c_sec_q    <= '0;
         disp_sel   <= '0;
         prev_tmr   <= '0;
         hr1        <= '0;
         hr2        <= '0;
         min1       <= '0;
         min2       <= '0;
      end else begin
         state      <= state_n;
         ring_cnt   <= ring_cnt_n;
         snooze_cnt <= snooze_cnt_n;
         ring_id    <= id_n;
         tgt_hr     <= tgt_hr_n;
         tgt_min    <= tgt_min_n;
         // Flags follow the next state so they change on the same edge as the FSM.
         alarm      <= (state_n == RING);
         snoozed    <= (state_n == SNOOZE);
         sel_q      <= btn_sel;
         snz_q      <= btn_snooze;
         dis_q      <= btn_dismiss;
         c_sec_q    <= c_sec;
         if (sel_p) begin
            if (disp_sel == SEL_MAX) begin
               disp_sel <= '0;
               prev_tmr <= '0;
            end else begin
               disp_sel <= disp_sel + 1'b1;
               prev_tmr <= TMR_LOAD;
            end
         end else if (prev_tmr != '0) begin
            prev_tmr <= prev_tmr - 1'b1;
            if (prev_tmr == TMR_ONE) disp_sel <= '0;
         end
         hr1  <= 4'(sel_hr / 6'd10);
         hr2  <= 4'(sel_hr % 6'd10);
         min1 <= 4'(sel_min / 6'd10);
         min2 <= 4'(sel_min % 6'd10);
      end
   end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed self-checking bench for multi_alarm_ctrl: trigger priority, snooze wrap,
// snooze limit, auto-silence, sw0 override, reset and display preview stepping.
module tb_multi_alarm_ctrl;

   localparam int unsigned NA = 4;
   localparam int unsigned PV = 20;

   logic          clk = 1'b0;
   logic          rst, sw0;
   logic [5:0]    c_hour, c_min, c_sec;
   logic [6*NA-1:0] a_hr_flat, a_min_flat;
   logic [NA-1:0] a_en;
   logic          btn_sel, btn_snooze, btn_dismiss;
   logic [3:0]    hr1, hr2, min1, min2;
   logic          alarm, snoozed;
   logic [1:0]    ring_id;

   int n_chk = 0;
   int n_fail = 0;

   multi_alarm_ctrl #(
      .NUM_ALARMS(NA), .PREVIEW_CYCLES(PV), .SNOOZE_MIN(5), .RING_SEC(59), .MAX_SNOOZE(3)
   ) dut (
      .clk(clk), .rst(rst), .sw0(sw0),
      .c_hour(c_hour), .c_min(c_min), .c_sec(c_sec),
      .a_hr_flat(a_hr_flat), .a_min_flat(a_min_flat), .a_en(a_en),
      .btn_sel(btn_sel), .btn_snooze(btn_snooze), .btn_dismiss(btn_dismiss),
      .hr1(hr1), .hr2(hr2), .min1(min1), .min2(min2),
      .alarm(alarm), .ring_id(ring_id), .snoozed(snoozed)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_digits(input string tag, input int a, input int b, input int c, input int d);
      chk({tag, ".hr1"}, 32'(hr1), 32'(a));
      chk({tag, ".hr2"}, 32'(hr2), 32'(b));
      chk({tag, ".min1"}, 32'(min1), 32'(c));
      chk({tag, ".min2"}, 32'(min2), 32'(d));
   endtask

   task automatic set_t(input int h, input int m, input int s);
      c_hour = 6'(h);
      c_min  = 6'(m);
      c_sec  = 6'(s);
      step();
   endtask

   task automatic set_slot(input int k, input int h, input int m);
      a_hr_flat[6*k +: 6]  = 6'(h);
      a_min_flat[6*k +: 6] = 6'(m);
   endtask

   task automatic press_snz();
      btn_snooze = 1'b1;
      step();
      btn_snooze = 1'b0;
   endtask

   task automatic press_dis();
      btn_dismiss = 1'b1;
      step();
      btn_dismiss = 1'b0;
   endtask

   task automatic press_sel();
      btn_sel = 1'b1;
      step();
      btn_sel = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; sw0 = 1'b1;
      c_hour = 6'd0; c_min = 6'd0; c_sec = 6'd0;
      a_hr_flat = '0; a_min_flat = '0; a_en = '0;
      btn_sel = 1'b0; btn_snooze = 1'b0; btn_dismiss = 1'b0;
      step(); step();
      chk("rst.alarm", 32'(alarm), 0);
      chk("rst.ring_id", 32'(ring_id), 0);
      chk("rst.snoozed", 32'(snoozed), 0);
      chk_digits("rst", 0, 0, 0, 0);
      rst = 1'b0;
      step();

      // slot 1 at 07:30
      set_slot(1, 7, 30); a_en = 4'b0010;
      set_t(7, 29, 59);
      chk("pre_trig.alarm", 32'(alarm), 0);
      set_t(7, 30, 0);
      chk("trig.alarm", 32'(alarm), 1);
      chk("trig.ring_id", 32'(ring_id), 1);
      chk_digits("trig", 0, 7, 3, 0);
      press_dis();
      chk("dismiss.alarm", 32'(alarm), 0);
      step();

      // priority: slots 0 and 2 at 06:00
      set_slot(0, 6, 0); set_slot(2, 6, 0); a_en = 4'b0111;
      set_t(5, 59, 59);
      set_t(6, 0, 0);
      chk("prio.alarm", 32'(alarm), 1);
      chk("prio.ring_id", 32'(ring_id), 0);
      press_dis(); step();
      a_en = 4'b0110;
      set_t(5, 59, 59);
      set_t(6, 0, 0);
      chk("prio2.alarm", 32'(alarm), 1);
      chk("prio2.ring_id", 32'(ring_id), 2);
      press_dis(); step();

      // snooze across hour/day wrap, then snooze limit
      set_slot(3, 23, 58); a_en = 4'b1000;
      set_t(23, 57, 59);
      set_t(23, 58, 0);
      chk("wrap.ring_id", 32'(ring_id), 3);
      press_snz();
      chk("snz1.snoozed", 32'(snoozed), 1);
      chk("snz1.alarm", 32'(alarm), 0);
      set_t(0, 1, 59);
      set_t(0, 2, 0);
      chk("snz1.early", 32'(alarm), 0);
      set_t(0, 2, 59);
      set_t(0, 3, 0);
      chk("snz1.ring", 32'(alarm), 1);
      chk("snz1.ring_id", 32'(ring_id), 3);
      chk("snz1.snoozed_lo", 32'(snoozed), 0);
      chk_digits("snz1", 0, 0, 0, 3);
      press_snz();
      set_t(0, 7, 59);
      set_t(0, 8, 0);
      chk("snz2.ring", 32'(alarm), 1);
      press_snz();
      chk("snz3.snoozed", 32'(snoozed), 1);
      set_t(0, 12, 59);
      set_t(0, 13, 0);
      chk("snz3.ring", 32'(alarm), 1);
      press_snz();
      chk("snz4.alarm", 32'(alarm), 0);
      chk("snz4.snoozed", 32'(snoozed), 0);
      set_t(0, 17, 59);
      set_t(0, 18, 0);
      chk("snz4.no_ring", 32'(alarm), 0);

      // auto-silence after 59 ticks
      set_slot(0, 10, 0); a_en = 4'b0001;
      set_t(9, 59, 59);
      set_t(10, 0, 0);
      chk("auto.start", 32'(alarm), 1);
      for (int s = 1; s <= 58; s++) set_t(10, 0, s);
      chk("auto.tick58", 32'(alarm), 1);
      set_t(10, 0, 59);
      chk("auto.tick59", 32'(alarm), 0);

      // snooze + dismiss on the same cycle
      set_slot(0, 11, 0);
      set_t(10, 59, 59);
      set_t(11, 0, 0);
      chk("both.start", 32'(alarm), 1);
      btn_snooze = 1'b1; btn_dismiss = 1'b1;
      step();
      btn_snooze = 1'b0; btn_dismiss = 1'b0;
      chk("both.alarm", 32'(alarm), 0);
      chk("both.snoozed", 32'(snoozed), 0);
      set_t(11, 4, 59);
      set_t(11, 5, 0);
      chk("both.no_ring", 32'(alarm), 0);

      // sw0 low during ring
      set_slot(0, 12, 0);
      set_t(11, 59, 59);
      set_t(12, 0, 0);
      chk("sw0.start", 32'(alarm), 1);
      sw0 = 1'b0;
      step();
      chk("sw0.alarm", 32'(alarm), 0);
      sw0 = 1'b1;
      step();
      chk("sw0.stays_off", 32'(alarm), 0);

      // asynchronous reset mid-ring, no re-trigger in the same minute
      set_t(12, 59, 59);
      set_slot(0, 13, 0);
      set_t(13, 0, 0);
      chk("arst.start", 32'(alarm), 1);
      rst = 1'b1;
      #1;
      chk("arst.async", 32'(alarm), 0);
      step();
      rst = 1'b0;
      step(); step();
      chk("arst.no_retrig", 32'(alarm), 0);

      // display stepping and preview timeout
      a_en = '0;
      set_slot(0, 10, 0); set_slot(1, 7, 30); set_slot(2, 6, 0); set_slot(3, 23, 58);
      set_t(14, 25, 0);
      step();
      chk_digits("disp.cur", 1, 4, 2, 5);
      press_sel();
      chk_digits("disp.s0", 1, 0, 0, 0);
      press_sel();
      chk_digits("disp.s1", 0, 7, 3, 0);
      press_sel();
      chk_digits("disp.s2", 0, 6, 0, 0);
      press_sel();
      chk_digits("disp.s3", 2, 3, 5, 8);
      press_sel();
      chk_digits("disp.wrap", 1, 4, 2, 5);
      press_sel();
      chk_digits("tmo.s0", 1, 0, 0, 0);
      for (int i = 0; i < int'(PV) - 1; i++) step();
      chk_digits("tmo.hold", 1, 0, 0, 0);
      step();
      chk_digits("tmo.back", 1, 4, 2, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_alarm_ctrl.md
# multi_alarm_ctrl

Parametrised multi-alarm controller for the digital clock. It holds NUM_ALARMS independently enabled alarm times and rings on a minute-boundary match. It supports snooze with a bounded repeat count, auto-silence after a ring timeout, and a button-driven display that steps through current time and each alarm. It sits between the timekeeping counter (current h/m/s) and the 7-segment display driver and buzzer.

## Interface
- NUM_ALARMS, 4: number of alarm slots, 1..8
- PREVIEW_CYCLES, 1000000: clk cycles an alarm preview stays on the display
- SNOOZE_MIN, 5: snooze interval in minutes, 1..59
- RING_SEC, 59: seconds of ringing before auto-silence, 1..63
- MAX_SNOOZE, 3: snoozes allowed per trigger
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw0  in  1  global alarm enable; low forces IDLE and alarm=0
- c_hour / c_min / c_sec  in  6 each  current time, binary (0-23 / 0-59 / 0-59)
- a_hr_flat / a_min_flat  in  6*NUM_ALARMS  alarm times; slot k at bits [6k+5:6k]
- a_en  in  NUM_ALARMS  per-slot enable
- btn_sel / btn_snooze / btn_dismiss  in  1  debounced, synchronous, level buttons
- hr1, hr2, min1, min2  out  4 each  BCD display digits (tens, ones)
- alarm  out  1  buzzer drive
- ring_id  out  $clog2(NUM_ALARMS) (min 1)  slot currently ringing or snoozed
- snoozed  out  1  high in SNOOZE state

## Operation
- Buttons: internal registered edge detect, pulse = btn & ~btn_q; one pulse per press.
- Second tick: sec_tick = (c_sec != c_sec_q). Minute boundary = sec_tick && c_sec==0.
- Ring FSM, states IDLE, RING, SNOOZE:
  - IDLE -> RING on minute boundary when an enabled slot matches {c_hour,c_min}. The lowest matching index wins and is latched into ring_id. ring_cnt=0, snooze_cnt=0.
  - RING: alarm=1. ring_cnt increments on sec_tick. At ring_cnt==RING_SEC -> IDLE (auto-silence).
  - RING + dismiss pulse -> IDLE.
  - RING + snooze pulse with snooze_cnt<MAX_SNOOZE -> SNOOZE. Target = current time + SNOOZE_MIN minutes, with minute wrap at 60 carrying into the hour and hour wrap at 24. snooze_cnt increments.
  - RING + snooze pulse with snooze_cnt==MAX_SNOOZE is treated as dismiss.
  - SNOOZE -> RING on minute boundary where {c_hour,c_min}==target. ring_id is kept and ring_cnt is cleared.
  - SNOOZE + dismiss pulse -> IDLE.
  - Snooze and dismiss in the same cycle: dismiss wins.
  - New matches from other slots are ignored outside IDLE.
  - sw0 low: FSM forced to IDLE every cycle. Counters are cleared.
- Display: pointer disp_sel 0..NUM_ALARMS, where 0 = current time.
  - btn_sel pulse: disp_sel = (disp_sel==NUM_ALARMS) ? 0 : disp_sel+1. preview timer reloads to PREVIEW_CYCLES.
  - The timer decrements each cycle while nonzero. Reaching 0 forces disp_sel=0.
  - A pulse that wraps disp_sel to 0 also clears the timer.
  - Digits come from the selected source: tens = v/10, ones = v%10.

## Timing
- Reset values: hr1=hr2=min1=min2=0, alarm=0, ring_id=0, snoozed=0, FSM IDLE, disp_sel=0, all counters 0, btn_q=0, c_sec_q=0.
- All outputs are registered.
- Digit latency: one cycle from time inputs or disp_sel change.
- Trigger: c_sec becomes 0 in cycle t with a match -> alarm=1 in t+1.
- Button rising edge sampled at t -> state and outputs change in t+1.
- Auto-silence: alarm falls in the cycle after the RING_SEC-th sec_tick.
- Reset asserted mid-ring drops alarm asynchronously. After release, an alarm whose minute is still current does not re-trigger until its next minute boundary.

## Test plan
- Slot 1 = 07:30 enabled, time rolls 07:29:59 -> 07:30:00 -> alarm=1 and ring_id=1 one cycle later. Digits read 0,7,3,0.
- Slots 0 and 2 both 06:00 enabled -> ring_id=0. Disable slot 0 and repeat next day -> ring_id=2.
- Ring at 23:58, press snooze -> snoozed=1, alarm=0. At 00:03:00 -> alarm=1 with the same ring_id. Covers the hour and day wrap.
- Snooze 3 times (MAX_SNOOZE=3), 4th snooze press -> IDLE, alarm=0, snoozed=0.
- Ring with no button for 59 second ticks -> alarm=0 after the 59th tick. Snooze and dismiss on the same cycle -> IDLE.
- btn_sel pressed 5 times with NUM_ALARMS=4 -> display shows slots 0,1,2,3, then current time. A single press followed by PREVIEW_CYCLES idle cycles returns the display to current time. sw0=0 during ring -> alarm=0 next cycle.
